// File: rtl/ixu_pkg.sv
// Shared decode types and helpers for the ixu_lane integer execution lane.
// IXU_MUL_EN selects whether the OP-class MUL encoding decodes as legal.
package ixu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_LUI,
        ALU_MUL
    } alu_op_e;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    typedef struct packed {
        alu_op_e     op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        use_imm;
        logic        wr;
        logic        illegal;
    } dec_t;

    // Base (funct7 = 0) operation for a funct3 value
    function automatic alu_op_e f3_op(input logic [2:0] f3);
        alu_op_e op;
        unique case (f3)
            F3_ADD:  op = ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic dec_t decode(input logic [31:0] inst);
        dec_t       d;
        logic [2:0] f3;
        logic [6:0] f7;
        f3        = inst[14:12];
        f7        = inst[31:25];
        d.op      = ALU_ADD;
        d.rd      = inst[11:7];
        d.rs1     = inst[19:15];
        d.rs2     = inst[24:20];
        d.imm     = {{20{inst[31]}}, inst[31:20]};
        d.use_imm = 1'b0;
        d.illegal = 1'b0;
        unique case (inst[6:0])
            OPC_OP: begin
                if (f7 == F7_BASE)
                    d.op = f3_op(f3);
                else if (f7 == F7_ALT && f3 == F3_ADD)
                    d.op = ALU_SUB;
                else if (f7 == F7_ALT && f3 == F3_SR)
                    d.op = ALU_SRA;
`ifdef IXU_MUL_EN
                else if (f7 == F7_MUL && f3 == F3_ADD)
                    d.op = ALU_MUL;
`endif
                else
                    d.illegal = 1'b1;
            end
            OPC_OPIMM: begin
                d.use_imm = 1'b1;
                d.rs2     = '0;
                // Shift immediates: upper funct bits select SRL/SRA
                if (f3 == F3_SLL) begin
                    d.op      = ALU_SLL;
                    d.illegal = (inst[31:26] != F7_BASE[6:1]);
                end else if (f3 == F3_SR) begin
                    if (inst[31:26] == F7_BASE[6:1])
                        d.op = ALU_SRL;
                    else if (inst[31:26] == F7_ALT[6:1])
                        d.op = ALU_SRA;
                    else
                        d.illegal = 1'b1;
                end else begin
                    d.op = f3_op(f3);
                end
            end
            OPC_LUI: begin
                d.op      = ALU_LUI;
                d.use_imm = 1'b1;
                d.imm     = {inst[31:12], 12'h000};
                d.rs1     = '0;
                d.rs2     = '0;
            end
            default: d.illegal = 1'b1;
        endcase
        d.wr = !d.illegal && (d.rd != 5'd0);
        return d;
    endfunction

endpackage

// File: rtl/ixu_alu.sv
// Combinational XLEN-wide ALU for ixu_lane.
// The multiplier exists only when IXU_MUL_EN is defined.
module ixu_alu
    import ixu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  alu_op_e          op,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    output logic [XLEN-1:0]  y
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] sh;

    assign sh = b[SHW-1:0];

    // Result select by decoded operation
    always_comb begin
        y = '0;
        unique case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_SLL:  y = a << sh;
            ALU_SLT:  y = XLEN'($signed(a) < $signed(b));
            ALU_SLTU: y = XLEN'(a < b);
            ALU_XOR:  y = a ^ b;
            ALU_SRL:  y = a >> sh;
            ALU_SRA:  y = XLEN'($signed(a) >>> sh);
            ALU_OR:   y = a | b;
            ALU_AND:  y = a & b;
            ALU_LUI:  y = b;
`ifdef IXU_MUL_EN
            ALU_MUL:  y = a * b;
`endif
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/ixu_lane.sv
// Three-stage integer lane (ID -> EX -> WB) with bypass and lane export.
// IXU_MUL_EN enables the single-cycle MUL encoding in the ALU.
module ixu_lane
    import ixu_pkg::*;
#(
    parameter  int XLEN       = 32,
    parameter  int NREG       = 32,
    parameter  int INT_BYPASS = 1,
    localparam int REG_AW     = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              inst_valid,
    input  logic [31:0]       inst,
    output logic [REG_AW-1:0] rs1_out,
    output logic [REG_AW-1:0] rs2_out,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic              is_rs1_fwd,
    input  logic              is_rs2_fwd,
    input  logic [XLEN-1:0]   rs1_fwd_data,
    input  logic [XLEN-1:0]   rs2_fwd_data,
    output logic              ex_fwd_valid,
    output logic [REG_AW-1:0] ex_fwd_rd,
    output logic [XLEN-1:0]   ex_fwd_data,
    output logic [REG_AW-1:0] rd_out,
    output logic [XLEN-1:0]   data_out,
    output logic              reg_file_wr_en,
    output logic              illegal_inst
);

    dec_t              dec;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [XLEN-1:0]   imm_x;
    logic [XLEN-1:0]   op1;
    logic [XLEN-1:0]   op2;
    logic              ex_byp;
    logic              wb_byp;

    alu_op_e           ex_op;
    logic              ex_valid;
    logic [XLEN-1:0]   ex_a;
    logic [XLEN-1:0]   ex_b;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_wr;
    logic              ex_ill;
    logic [XLEN-1:0]   alu_y;

    logic              wb_valid;
    logic              wb_wr;
    logic              wb_ill;
    logic              wb_fired;

    assign dec     = decode(inst);
    assign id_rs1  = dec.rs1[REG_AW-1:0];
    assign id_rs2  = dec.rs2[REG_AW-1:0];
    assign rs1_out = inst[15 +: REG_AW];
    assign rs2_out = inst[20 +: REG_AW];
    assign imm_x   = XLEN'($signed(dec.imm));

    assign ex_byp = (INT_BYPASS != 0) && ex_valid && ex_wr;
    assign wb_byp = (INT_BYPASS != 0) && wb_valid && wb_wr;

    // rs1 operand: x0, other lane, own EX, own WB, then reg file
    always_comb begin
        op1 = rs1_data;
        if (id_rs1 == '0)
            op1 = '0;
        else if (is_rs1_fwd)
            op1 = rs1_fwd_data;
        else if (ex_byp && ex_rd == id_rs1)
            op1 = alu_y;
        else if (wb_byp && rd_out == id_rs1)
            op1 = data_out;
    end

    // rs2 operand: same priority, immediate substituted when used
    always_comb begin
        op2 = rs2_data;
        if (dec.use_imm)
            op2 = imm_x;
        else if (id_rs2 == '0)
            op2 = '0;
        else if (is_rs2_fwd)
            op2 = rs2_fwd_data;
        else if (ex_byp && ex_rd == id_rs2)
            op2 = alu_y;
        else if (wb_byp && rd_out == id_rs2)
            op2 = data_out;
    end

    // ID/EX register: flush kills, stall holds, otherwise load or bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid <= 1'b0;
            ex_op    <= ALU_ADD;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_rd    <= '0;
            ex_wr    <= 1'b0;
            ex_ill   <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (!stall) begin
            ex_valid <= inst_valid;
            ex_op    <= dec.op;
            ex_a     <= op1;
            ex_b     <= op2;
            ex_rd    <= dec.rd[REG_AW-1:0];
            ex_wr    <= dec.wr;
            ex_ill   <= dec.illegal;
        end
    end

    ixu_alu #(
        .XLEN (XLEN)
    ) u_alu (
        .op (ex_op),
        .a  (ex_a),
        .b  (ex_b),
        .y  (alu_y)
    );

    // EX/WB register; wb_fired marks a WB entry whose strobe already fired
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_wr    <= 1'b0;
            wb_ill   <= 1'b0;
            wb_fired <= 1'b0;
            rd_out   <= '0;
            data_out <= '0;
        end else if (flush) begin
            wb_valid <= 1'b0;
            wb_fired <= 1'b0;
        end else if (stall) begin
            wb_fired <= wb_valid;
        end else begin
            wb_valid <= ex_valid;
            wb_wr    <= ex_wr;
            wb_ill   <= ex_ill;
            wb_fired <= 1'b0;
            if (ex_valid) begin
                rd_out   <= ex_rd;
                data_out <= alu_y;
            end
        end
    end

    assign reg_file_wr_en = wb_valid && wb_wr && !wb_fired;
    assign illegal_inst   = wb_valid && wb_ill && !wb_fired;

    assign ex_fwd_valid = ex_valid && ex_wr;
    assign ex_fwd_rd    = ex_fwd_valid ? ex_rd : '0;
    assign ex_fwd_data  = ex_fwd_valid ? alu_y : '0;

endmodule

// File: tb/tb_ixu_lane.sv
// Self-checking bench for ixu_lane: directed scenarios then random stream
// checked against an in-order architectural model of the lane.
module tb_ixu_lane;

    typedef enum int {
        M_ADD, M_SUB, M_SLL, M_SLT, M_SLTU, M_XOR, M_SRL, M_SRA, M_OR, M_AND,
        M_ADDI, M_SLTI, M_SLTIU, M_XORI, M_ORI, M_ANDI, M_SLLI, M_SRLI, M_SRAI,
        M_LUI, M_MUL, M_BAD, M_BADR
    } mn_e;

    typedef struct packed {
        logic        wr;
        logic        ill;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        inst_valid;
    logic [31:0] inst;
    logic [4:0]  rs1_out;
    logic [4:0]  rs2_out;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        is_rs1_fwd;
    logic        is_rs2_fwd;
    logic [31:0] rs1_fwd_data;
    logic [31:0] rs2_fwd_data;
    logic        ex_fwd_valid;
    logic [4:0]  ex_fwd_rd;
    logic [31:0] ex_fwd_data;
    logic [4:0]  rd_out;
    logic [31:0] data_out;
    logic        reg_file_wr_en;
    logic        illegal_inst;

    logic        rf_clr;
    logic [31:0] rf_dut [32];
    logic [31:0] arch [32];
    exp_t        pipe [$];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    ixu_lane dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .flush          (flush),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .rs1_out        (rs1_out),
        .rs2_out        (rs2_out),
        .rs1_data       (rs1_data),
        .rs2_data       (rs2_data),
        .is_rs1_fwd     (is_rs1_fwd),
        .is_rs2_fwd     (is_rs2_fwd),
        .rs1_fwd_data   (rs1_fwd_data),
        .rs2_fwd_data   (rs2_fwd_data),
        .ex_fwd_valid   (ex_fwd_valid),
        .ex_fwd_rd      (ex_fwd_rd),
        .ex_fwd_data    (ex_fwd_data),
        .rd_out         (rd_out),
        .data_out       (data_out),
        .reg_file_wr_en (reg_file_wr_en),
        .illegal_inst   (illegal_inst)
    );

    // Register file the lane writes into and reads from
    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 32; i++) rf_dut[i] <= 32'h0;
        end else if (reg_file_wr_en) begin
            rf_dut[rd_out] <= data_out;
        end
    end

    assign rs1_data = rf_dut[rs1_out];
    assign rs2_data = rf_dut[rs2_out];

    function automatic logic [31:0] enc(input mn_e m, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [19:0] imm);
        logic [11:0] i12;
        logic [4:0]  sh;
        i12 = imm[11:0];
        sh  = imm[4:0];
        case (m)
            M_ADD:   return {7'h00, rs2, rs1, 3'd0, rd, 7'h33};
            M_SUB:   return {7'h20, rs2, rs1, 3'd0, rd, 7'h33};
            M_SLL:   return {7'h00, rs2, rs1, 3'd1, rd, 7'h33};
            M_SLT:   return {7'h00, rs2, rs1, 3'd2, rd, 7'h33};
            M_SLTU:  return {7'h00, rs2, rs1, 3'd3, rd, 7'h33};
            M_XOR:   return {7'h00, rs2, rs1, 3'd4, rd, 7'h33};
            M_SRL:   return {7'h00, rs2, rs1, 3'd5, rd, 7'h33};
            M_SRA:   return {7'h20, rs2, rs1, 3'd5, rd, 7'h33};
            M_OR:    return {7'h00, rs2, rs1, 3'd6, rd, 7'h33};
            M_AND:   return {7'h00, rs2, rs1, 3'd7, rd, 7'h33};
            M_MUL:   return {7'h01, rs2, rs1, 3'd0, rd, 7'h33};
            M_BADR:  return {7'h20, rs2, rs1, 3'd1, rd, 7'h33};
            M_ADDI:  return {i12, rs1, 3'd0, rd, 7'h13};
            M_SLTI:  return {i12, rs1, 3'd2, rd, 7'h13};
            M_SLTIU: return {i12, rs1, 3'd3, rd, 7'h13};
            M_XORI:  return {i12, rs1, 3'd4, rd, 7'h13};
            M_ORI:   return {i12, rs1, 3'd6, rd, 7'h13};
            M_ANDI:  return {i12, rs1, 3'd7, rd, 7'h13};
            M_SLLI:  return {7'h00, sh, rs1, 3'd1, rd, 7'h13};
            M_SRLI:  return {7'h00, sh, rs1, 3'd5, rd, 7'h13};
            M_SRAI:  return {7'h20, sh, rs1, 3'd5, rd, 7'h13};
            M_LUI:   return {imm, rd, 7'h37};
            default: return {i12, rs1, 3'd0, rd, 7'h63};
        endcase
    endfunction

    function automatic bit is_illegal(input mn_e m);
        if (m == M_BAD || m == M_BADR) return 1'b1;
`ifdef IXU_MUL_EN
        return 1'b0;
`else
        return (m == M_MUL);
`endif
    endfunction

    // Architectural result of one instruction from its operand values
    function automatic logic [31:0] model(input mn_e m, input logic [31:0] a,
                                          input logic [31:0] b, input logic [19:0] imm);
        logic [31:0] si;
        logic [4:0]  s;
        si = {{20{imm[11]}}, imm[11:0]};
        s  = imm[4:0];
        case (m)
            M_ADD:   return a + b;
            M_SUB:   return a - b;
            M_SLL:   return a << b[4:0];
            M_SLT:   return {31'b0, ($signed(a) < $signed(b))};
            M_SLTU:  return {31'b0, (a < b)};
            M_XOR:   return a ^ b;
            M_SRL:   return a >> b[4:0];
            M_SRA:   return $signed(a) >>> b[4:0];
            M_OR:    return a | b;
            M_AND:   return a & b;
            M_ADDI:  return a + si;
            M_SLTI:  return {31'b0, ($signed(a) < $signed(si))};
            M_SLTIU: return {31'b0, (a < si)};
            M_XORI:  return a ^ si;
            M_ORI:   return a | si;
            M_ANDI:  return a & si;
            M_SLLI:  return a << s;
            M_SRLI:  return a >> s;
            M_SRAI:  return $signed(a) >>> s;
            M_LUI:   return {imm, 12'h000};
            M_MUL:   return a * b;
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (pipe.size() >= 2) begin
            e = pipe.pop_front();
            chk("wb_wr_en", 32'(reg_file_wr_en), 32'(e.wr));
            if (e.wr) begin
                chk("wb_rd", 32'(rd_out), 32'(e.rd));
                chk("wb_data", data_out, e.data);
            end
            chk("wb_illegal", 32'(illegal_inst), 32'(e.ill));
        end
    endtask

    task automatic bubble();
        inst_valid = 1'b0;
        is_rs1_fwd = 1'b0;
        is_rs2_fwd = 1'b0;
        pipe.push_back('0);
        step();
    endtask

    task automatic issue(input mn_e m, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [19:0] imm,
                         input bit f1, input logic [31:0] d1,
                         input bit f2, input logic [31:0] d2);
        exp_t        e;
        logic [31:0] a;
        logic [31:0] b;
        logic        ill;
        inst         = enc(m, rd, rs1, rs2, imm);
        inst_valid   = 1'b1;
        is_rs1_fwd   = f1;
        rs1_fwd_data = d1;
        is_rs2_fwd   = f2;
        rs2_fwd_data = d2;
        a = (rs1 == 5'd0) ? 32'h0 : (f1 ? d1 : arch[rs1]);
        b = (rs2 == 5'd0) ? 32'h0 : (f2 ? d2 : arch[rs2]);
        ill    = is_illegal(m);
        e.wr   = !ill && (rd != 5'd0);
        e.ill  = ill;
        e.rd   = rd;
        e.data = model(m, a, b, imm);
        if (e.wr) arch[rd] = e.data;
        pipe.push_back(e);
        step();
        chk("ex_fwd_valid", 32'(ex_fwd_valid), 32'(e.wr));
        if (e.wr) begin
            chk("ex_fwd_rd", 32'(ex_fwd_rd), 32'(e.rd));
            chk("ex_fwd_data", ex_fwd_data, e.data);
        end
    endtask

    initial begin
        logic [31:0] sv12;
        logic [31:0] sv14;
        logic [31:0] sv15;
        for (int i = 0; i < 32; i++) arch[i] = 32'h0;
        rst          = 1'b1;
        rf_clr       = 1'b1;
        stall        = 1'b0;
        flush        = 1'b0;
        inst_valid   = 1'b0;
        inst         = 32'h0;
        is_rs1_fwd   = 1'b0;
        is_rs2_fwd   = 1'b0;
        rs1_fwd_data = 32'h0;
        rs2_fwd_data = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_en", 32'(reg_file_wr_en), 32'h0);
        chk("rst_rd_out", 32'(rd_out), 32'h0);
        chk("rst_data_out", data_out, 32'h0);
        chk("rst_ex_fwd_valid", 32'(ex_fwd_valid), 32'h0);
        chk("rst_ex_fwd_data", ex_fwd_data, 32'h0);
        chk("rst_illegal", 32'(illegal_inst), 32'h0);
        rst    = 1'b0;
        rf_clr = 1'b0;

        // Dependent pair back to back, then export, shifts and compares
        issue(M_ADDI, 5'd1, 5'd0, 5'd0, 20'd5, 0, 0, 0, 0);
        issue(M_ADD, 5'd2, 5'd1, 5'd1, 20'd0, 0, 0, 0, 0);
        issue(M_ADDI, 5'd3, 5'd4, 5'd0, 20'd1, 1, 32'h100, 0, 0);
        issue(M_SRAI, 5'd5, 5'd6, 5'd0, 20'd4, 1, 32'h8000_0000, 0, 0);
        issue(M_SLTU, 5'd7, 5'd1, 5'd2, 20'd0, 1, 32'h1, 1, 32'hFFFF_FFFF);
        issue(M_ADDI, 5'd0, 5'd1, 5'd0, 20'd9, 0, 0, 0, 0);
        issue(M_MUL, 5'd8, 5'd1, 5'd2, 20'd0, 1, 32'd7, 1, 32'd6);
        issue(M_BAD, 5'd4, 5'd1, 5'd0, 20'd3, 0, 0, 0, 0);
        bubble();
        bubble();
        chk("x5_srai", arch[5], 32'hF800_0000);

        // Stall with an instruction in WB and another in EX
        issue(M_ADDI, 5'd9, 5'd0, 5'd0, 20'd77, 0, 0, 0, 0);
        issue(M_ADDI, 5'd10, 5'd0, 5'd0, 20'd88, 0, 0, 0, 0);
        stall      = 1'b1;
        inst_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("stall_wr_en", 32'(reg_file_wr_en), 32'h0);
            chk("stall_rd_out", 32'(rd_out), 32'd9);
            chk("stall_data_out", data_out, 32'd77);
            chk("stall_ex_rd", 32'(ex_fwd_rd), 32'd10);
        end
        stall = 1'b0;
        bubble();
        bubble();

        // Flush: WB entry still writes, EX entry and incoming inst die
        sv12 = arch[12];
        issue(M_ADDI, 5'd11, 5'd0, 5'd0, 20'd11, 0, 0, 0, 0);
        issue(M_ADDI, 5'd12, 5'd0, 5'd0, 20'd12, 0, 0, 0, 0);
        flush      = 1'b1;
        inst       = enc(M_ADDI, 5'd13, 5'd0, 5'd0, 20'd13);
        inst_valid = 1'b1;
        is_rs1_fwd = 1'b0;
        is_rs2_fwd = 1'b0;
        @(posedge clk);
        #1;
        flush      = 1'b0;
        inst_valid = 1'b0;
        chk("flush_wr_en", 32'(reg_file_wr_en), 32'h0);
        chk("flush_ex_valid", 32'(ex_fwd_valid), 32'h0);
        @(posedge clk);
        #1;
        chk("flush_wr_en2", 32'(reg_file_wr_en), 32'h0);
        pipe.delete();
        arch[12] = sv12;

        // Asynchronous reset in the middle of a stream
        sv14 = arch[14];
        sv15 = arch[15];
        issue(M_ADDI, 5'd14, 5'd0, 5'd0, 20'd14, 0, 0, 0, 0);
        issue(M_ADDI, 5'd15, 5'd0, 5'd0, 20'd15, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_wr_en", 32'(reg_file_wr_en), 32'h0);
        chk("arst_rd_out", 32'(rd_out), 32'h0);
        chk("arst_data_out", data_out, 32'h0);
        chk("arst_ex_fwd_valid", 32'(ex_fwd_valid), 32'h0);
        chk("arst_ex_fwd_data", ex_fwd_data, 32'h0);
        inst_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        pipe.delete();
        arch[14] = sv14;
        arch[15] = sv15;
        chk("x11_kept", arch[11], 32'd11);

        // Random stream over a small register window
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0)
                bubble();
            else
                issue(mn_e'($urandom_range(0, 22)),
                      5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)),
                      20'($urandom),
                      ($urandom_range(0, 3) == 0), $urandom,
                      ($urandom_range(0, 3) == 0), $urandom);
        end
        bubble();
        bubble();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
